// File: rtl/mcycle.sv
// mcycle: multi-cycle integer multiply / divide unit.
// One bit is processed per clock: shift-add multiply, restoring divide.
// Both algorithms work on operand magnitudes. A final cycle applies the sign
// correction and writes the registered results.
// Optional build macro MCYCLE_DIV0_FLAG_EN adds the DivByZero output.
module mcycle #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
`ifdef MCYCLE_DIV0_FLAG_EN
   ,output logic             DivByZero
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [1:0]       op;        // [1]=divide, [0]=unsigned
    logic             neg1;      // operand signs (signed ops only)
    logic             neg2;
    logic             div0;      // latched divisor was zero
    logic [WIDTH-1:0] a_raw;     // dividend as given, for the div-by-zero remainder
    logic [WIDTH-1:0] m;         // multiplicand magnitude / divisor magnitude
    logic [WIDTH-1:0] hi;        // product high half / partial remainder
    logic [WIDTH-1:0] lo;        // product low half (multiplier shifts out) / quotient (dividend shifts out)
    logic [CW-1:0]    cnt;

    // Magnitude of a value, treating it as two's complement when sgn is set.
    // The most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    logic             in_signed;
    logic [WIDTH-1:0] in_mag1;
    logic [WIDTH-1:0] in_mag2;

    // Operand magnitudes presented at the start edge
    always_comb begin
        in_signed = ~MCycleOp[0];
        in_mag1   = mag(Operand1, in_signed);
        in_mag2   = mag(Operand2, in_signed);
    end

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fin1;
    logic [WIDTH-1:0]   fin2;

    // One iteration of each algorithm, plus the sign-corrected final results
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
        div_sh   = {hi, lo[WIDTH-1]};
        div_diff = div_sh - {1'b0, m};

        prod = {hi, lo};
        quo  = lo;
        rem  = hi;
        if (!op[0] && (neg1 ^ neg2)) begin
            prod = ~prod + 1'b1;
            quo  = ~quo + 1'b1;
        end
        if (!op[0] && neg1)
            rem = ~rem + 1'b1;

        fin1 = prod[WIDTH-1:0];
        fin2 = prod[2*WIDTH-1:WIDTH];
        if (op[1]) begin
            if (div0) begin
                fin1 = '1;
                fin2 = a_raw;
            end else begin
                fin1 = quo;
                fin2 = rem;
            end
        end
    end

    // Control FSM and datapath: latch on Start, iterate WIDTH times, finalize
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state   <= IDLE;
            Busy    <= 1'b0;
            op      <= '0;
            neg1    <= 1'b0;
            neg2    <= 1'b0;
            div0    <= 1'b0;
            a_raw   <= '0;
            m       <= '0;
            hi      <= '0;
            lo      <= '0;
            cnt     <= '0;
            Result1 <= '0;
            Result2 <= '0;
`ifdef MCYCLE_DIV0_FLAG_EN
            DivByZero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state <= RUN;
                        Busy  <= 1'b1;
                        op    <= MCycleOp;
                        neg1  <= in_signed & Operand1[WIDTH-1];
                        neg2  <= in_signed & Operand2[WIDTH-1];
                        div0  <= (Operand2 == '0);
                        a_raw <= Operand1;
                        m     <= MCycleOp[1] ? in_mag2 : in_mag1;
                        hi    <= '0;
                        lo    <= MCycleOp[1] ? in_mag1 : in_mag2;
                        cnt   <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                        if (!op[1]) begin
                            hi <= mul_sum[WIDTH:1];
                            lo <= {mul_sum[0], lo[WIDTH-1:1]};
                        end else if (!div_diff[WIDTH]) begin
                            hi <= div_diff[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b1};
                        end else begin
                            hi <= div_sh[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        state   <= IDLE;
                        Busy    <= 1'b0;
                        Result1 <= fin1;
                        Result2 <= fin2;
`ifdef MCYCLE_DIV0_FLAG_EN
                        DivByZero <= op[1] & div0;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcycle.sv
// tb_mcycle: directed bench for mcycle (WIDTH=4).
// A behavioural model derives results from integer arithmetic and the
// timing from the operation length. A compare process checks the outputs
// against that model every cycle. Directed literal expectations pin the
// model down.
module tb_mcycle;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] Result1;
    logic [W-1:0] Result2;
    logic         Busy;
`ifdef MCYCLE_DIV0_FLAG_EN
    logic         DivByZero;
`endif

    int vectors    = 0;
    int miscompares = 0;

    mcycle #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2), .Busy(Busy)
`ifdef MCYCLE_DIV0_FLAG_EN
       ,.DivByZero(DivByZero)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference arithmetic: returns {Result2, Result1}
    function automatic logic [2*W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint x, y, p, q, r;
        logic [63:0] pv;
        logic [63:0] qv;
        logic [63:0] rv;
        if (op[0]) begin
            x = longint'(a);
            y = longint'(b);
        end else begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end
        if (!op[1]) begin
            p  = x * y;
            pv = p;
            return pv[2*W-1:0];
        end
        if (b == '0)
            return {a, {W{1'b1}}};
        q  = x / y;
        r  = x % y;
        qv = q;
        rv = r;
        return {rv[W-1:0], qv[W-1:0]};
    endfunction

    // Model state
    logic           m_busy;
    int             m_cnt;
    logic [2*W-1:0] m_res;
    logic [2*W-1:0] m_pend;
    logic           m_dz;
    logic           m_dz_pend;

    // Model: an accepted request keeps the unit busy for W+1 edges, then publishes
    always @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            m_res     <= '0;
            m_pend    <= '0;
            m_dz      <= 1'b0;
            m_dz_pend <= 1'b0;
        end else if (!m_busy) begin
            if (Start) begin
                m_busy    <= 1'b1;
                m_cnt     <= W + 1;
                m_pend    <= ref_op(MCycleOp, Operand1, Operand2);
                m_dz_pend <= MCycleOp[1] && (Operand2 == '0);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy <= 1'b0;
                m_res  <= m_pend;
                m_dz   <= m_dz_pend;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge CLK) begin
        vectors++;
        if (Busy !== m_busy || {Result2, Result1} !== m_res) begin
            miscompares++;
            $display("FAIL model t=%0t: got busy=%b res=%h, expected busy=%b res=%h",
                     $time, Busy, {Result2, Result1}, m_busy, m_res);
        end
`ifdef MCYCLE_DIV0_FLAG_EN
        vectors++;
        if (DivByZero !== m_dz) begin
            miscompares++;
            $display("FAIL div0_flag t=%0t: got %b, expected %b", $time, DivByZero, m_dz);
        end
`endif
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Issue an op at a negedge (Start stays high), scramble operands while busy,
    // then wait for Busy to fall and check the literal expectation.
    task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] e2, input logic [W-1:0] e1,
                          input logic edz);
        int busy_cycles = 0;
        int guard = 0;
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        @(posedge CLK);
        @(negedge CLK);
        MCycleOp = 2'(op + 1);
        Operand1 = W'($urandom);
        Operand2 = W'($urandom);
        while (Busy === 1'b1 && guard < 40) begin
            busy_cycles++;
            guard++;
            @(negedge CLK);
        end
        check({name, "_timeout"}, 32'(guard >= 40), 32'd0);
        check({name, "_busy_len"}, 32'(busy_cycles), 32'(W + 1));
        check({name, "_res"}, {24'd0, Result2, Result1}, {24'd0, e2, e1});
`ifdef MCYCLE_DIV0_FLAG_EN
        check({name, "_dz"}, 32'(DivByZero), 32'(edz));
`else
        if (edz) begin end
`endif
    endtask

    initial begin
        RESET    = 1'b0;
        Start    = 1'b0;
        MCycleOp = 2'b00;
        Operand1 = '0;
        Operand2 = '0;
        repeat (2) @(negedge CLK);
        check("reset_state", {29'd0, Busy, |Result1, |Result2}, 32'd0);
        #2 RESET = 1'b1;
        @(negedge CLK);

        run_op("sdiv_m7_3",   2'b10, 4'b1001, 4'b0011, 4'b1111, 4'b1110, 1'b0);
        run_op("smul_m7_7",   2'b00, 4'b1001, 4'b0111, 4'b1100, 4'b1111, 1'b0);
        run_op("umul_3_3",    2'b01, 4'b0011, 4'b0011, 4'b0000, 4'b1001, 1'b0);
        run_op("udiv_14_15",  2'b11, 4'b1110, 4'b1111, 4'b1110, 4'b0000, 1'b0);
        run_op("udiv0",       2'b11, 4'b0101, 4'b0000, 4'b0101, 4'b1111, 1'b1);
        run_op("sdiv_ovf",    2'b10, 4'b1000, 4'b1111, 4'b0000, 4'b1000, 1'b0);
        run_op("smul_m8_m8",  2'b00, 4'b1000, 4'b1000, 4'b0100, 4'b0000, 1'b0);
        run_op("sdiv0",       2'b10, 4'b1001, 4'b0000, 4'b1001, 4'b1111, 1'b1);
        run_op("sdiv_7_m2",   2'b10, 4'b0111, 4'b1110, 4'b0001, 4'b1101, 1'b0);
        run_op("umul_15_15",  2'b01, 4'b1111, 4'b1111, 4'b1110, 4'b0001, 1'b0);
        run_op("smul_0_m1",   2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b0);

        // Reset two cycles into a multiply clears everything immediately
        Start    = 1'b1;
        MCycleOp = 2'b01;
        Operand1 = 4'b0111;
        Operand2 = 4'b0101;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        #2 RESET = 1'b0;
        #1 check("reset_abort", {29'd0, Busy, |Result1, |Result2}, 32'd0);
        Start = 1'b0;
        @(negedge CLK);
        #2 RESET = 1'b1;
        repeat (8) begin
            @(negedge CLK);
            check("idle_no_start", 32'(Busy), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
